counter_cmd_master: RTL and testbench

Command initiator for the SRAM multi-counter block. Accepts host requests through a ready/valid queue, issues them one per cycle on the counter's command port (`valid`/`id`/`data`/`cmd`), and collects the counter's READ responses (`output_valid`/`output_data`) into a response queue drained by the host. Sits between the host/test agent and the counter, and provides credit-based flow control so that no READ response is ever lost.

---
 rtl/counter_cmd_master.sv | 304 ++++++++++++++++++++++++++++++
 tb/tb_counter_cmd_master.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_master.sv
// counter_cmd_master
//
// Sends commands to the SRAM multi-counter block and collects its READ responses.
// Host requests are accepted through a ready/valid request queue. They are issued one
// per cycle on the counter command port, strictly in acceptance order. READ responses
// are pushed into a response queue, which the host drains.
//
// A READ is issued only when the response queue has space reserved for its answer:
// rsp_count + inflight < RSP_DEPTH. A response therefore always has a free slot.
//
// Ports
//   clk, rst_n                         clock, asynchronous active-low reset
//   req_valid/req_ready                host request handshake
//   req_id/req_data/req_cmd            request payload (LOAD=0 CLEAR=1 INC=2 DEC=3 READ=4)
//   cnt_valid/cnt_id/cnt_data/cnt_cmd  registered command to the counter
//   cnt_rsp_valid/cnt_rsp_data         counter output_valid / output_data
//   rsp_valid/rsp_ready/rsp_data       host response handshake (head of response queue)
//   busy                               anything queued, issued or in flight
//   err                                sticky: [0] illegal cmd dropped, [1] unexpected response
//
// Optional feature: define COUNTER_CMD_MASTER_STATS_EN to add the stat_issued and
// stat_reads outputs. Both are 16-bit wrapping event counters.

module counter_cmd_master #(
  parameter int unsigned ID_W      = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned REQ_DEPTH = 4,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  // host request
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ID_W-1:0]   req_id,
  input  logic [DATA_W-1:0] req_data,
  input  logic [2:0]        req_cmd,
  // counter command
  output logic              cnt_valid,
  output logic [ID_W-1:0]   cnt_id,
  output logic [DATA_W-1:0] cnt_data,
  output logic [2:0]        cnt_cmd,
  // counter response
  input  logic              cnt_rsp_valid,
  input  logic [DATA_W-1:0] cnt_rsp_data,
  // host response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  // status
  output logic              busy,
  output logic [1:0]        err
`ifdef COUNTER_CMD_MASTER_STATS_EN
  ,
  output logic [15:0]       stat_issued,
  output logic [15:0]       stat_reads
`endif
);

  localparam int unsigned ReqAw = $clog2(REQ_DEPTH);
  localparam int unsigned RspAw = $clog2(RSP_DEPTH);
  localparam int unsigned ReqW  = 3 + ID_W + DATA_W;
  // Wide enough for rsp_count (up to RSP_DEPTH) plus inflight (up to 3).
  localparam int unsigned CrW   = RspAw + 3;

  localparam logic [2:0] CmdRead = 3'b100;

  // ------------------------------------------------------------------
  // Start-up: req_ready stays low until the first edge after reset release.
  // ------------------------------------------------------------------
  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // ------------------------------------------------------------------
  // Request queue. Each pointer has one extra bit, so full and empty can be told apart.
  // ------------------------------------------------------------------
  logic [ReqW-1:0]  req_mem [REQ_DEPTH];
  logic [ReqAw:0]   req_wr_q, req_wr_d;
  logic [ReqAw:0]   req_rd_q, req_rd_d;
  logic [ReqAw:0]   req_count;
  logic             req_full, req_empty;
  logic             req_push, req_pop;
  logic [ReqW-1:0]  head;
  logic [2:0]       head_cmd;
  logic [ID_W-1:0]  head_id;
  logic [DATA_W-1:0] head_data;

  assign req_count = req_wr_q - req_rd_q;
  assign req_empty = (req_wr_q == req_rd_q);
  assign req_full  = (req_wr_q[ReqAw] != req_rd_q[ReqAw]) &&
                     (req_wr_q[ReqAw-1:0] == req_rd_q[ReqAw-1:0]);

  assign req_ready = run_q & ~req_full;
  assign req_push  = req_valid & req_ready;

  assign head      = req_mem[req_rd_q[ReqAw-1:0]];
  assign head_cmd  = head[ReqW-1 -: 3];
  assign head_id   = head[ID_W+DATA_W-1 -: ID_W];
  assign head_data = head[DATA_W-1:0];

  always_ff @(posedge clk) begin
    if (req_push) begin
      req_mem[req_wr_q[ReqAw-1:0]] <= {req_cmd, req_id, req_data};
    end
  end

  always_comb begin
    req_wr_d = req_wr_q;
    req_rd_d = req_rd_q;
    if (req_push) req_wr_d = req_wr_q + 1'b1;
    if (req_pop)  req_rd_d = req_rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_wr_q <= '0;
      req_rd_q <= '0;
    end else begin
      req_wr_q <= req_wr_d;
      req_rd_q <= req_rd_d;
    end
  end

  // ------------------------------------------------------------------
  // Response queue
  // ------------------------------------------------------------------
  logic [DATA_W-1:0] rsp_mem [RSP_DEPTH];
  logic [RspAw:0]    rsp_wr_q, rsp_wr_d;
  logic [RspAw:0]    rsp_rd_q, rsp_rd_d;
  logic [RspAw:0]    rsp_count;
  logic              rsp_empty, rsp_full;
  logic              rsp_push, rsp_pop;

  assign rsp_count = rsp_wr_q - rsp_rd_q;
  assign rsp_empty = (rsp_wr_q == rsp_rd_q);
  assign rsp_full  = (rsp_wr_q[RspAw] != rsp_rd_q[RspAw]) &&
                     (rsp_wr_q[RspAw-1:0] == rsp_rd_q[RspAw-1:0]);

  assign rsp_valid = ~rsp_empty;
  assign rsp_pop   = rsp_valid & rsp_ready;
  // Gate with empty so that rsp_data reads 0 after reset, not unwritten storage.
  assign rsp_data  = rsp_empty ? '0 : rsp_mem[rsp_rd_q[RspAw-1:0]];

  always_ff @(posedge clk) begin
    if (rsp_push) begin
      rsp_mem[rsp_wr_q[RspAw-1:0]] <= cnt_rsp_data;
    end
  end

  always_comb begin
    rsp_wr_d = rsp_wr_q;
    rsp_rd_d = rsp_rd_q;
    if (rsp_push) rsp_wr_d = rsp_wr_q + 1'b1;
    if (rsp_pop)  rsp_rd_d = rsp_rd_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_wr_q <= '0;
      rsp_rd_q <= '0;
    end else begin
      rsp_wr_q <= rsp_wr_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  // ------------------------------------------------------------------
  // In-flight READ tracking and credit check
  // ------------------------------------------------------------------
  logic [1:0]     inflight_q, inflight_d;
  logic           rsp_accept, rsp_spurious;
  logic [CrW-1:0] credit_used;
  logic           credit_ok;

  assign rsp_accept   = cnt_rsp_valid & (inflight_q != 2'd0);
  assign rsp_spurious = cnt_rsp_valid & (inflight_q == 2'd0);
  assign rsp_push     = rsp_accept;

  // A pop on this edge is not counted as a free slot. That is conservative, but it
  // keeps the credit path free of rsp_ready.
  assign credit_used = CrW'(rsp_count) + CrW'(inflight_q);
  assign credit_ok   = (credit_used < CrW'(RSP_DEPTH));

  // ------------------------------------------------------------------
  // Issue decision for the request-queue head
  // ------------------------------------------------------------------
  logic issue_load, issue_read, illegal;

  always_comb begin
    req_pop    = 1'b0;
    issue_load = 1'b0;
    issue_read = 1'b0;
    illegal    = 1'b0;
    if (!req_empty) begin
      if (head_cmd > CmdRead) begin
        // Codes 101..111 are dropped without reaching the counter.
        req_pop = 1'b1;
        illegal = 1'b1;
      end else if (head_cmd == CmdRead) begin
        if (credit_ok) begin
          req_pop    = 1'b1;
          issue_load = 1'b1;
          issue_read = 1'b1;
        end
      end else begin
        req_pop    = 1'b1;
        issue_load = 1'b1;
      end
    end
  end

  always_comb begin
    inflight_d = inflight_q;
    unique case ({issue_read, rsp_accept})
      2'b10:   inflight_d = inflight_q + 2'd1;
      2'b01:   inflight_d = inflight_q - 2'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  // ------------------------------------------------------------------
  // Issue register. id/data/cmd hold their values when nothing is loaded.
  // ------------------------------------------------------------------
  logic              cnt_valid_q, cnt_valid_d;
  logic [ID_W-1:0]   cnt_id_q, cnt_id_d;
  logic [DATA_W-1:0] cnt_data_q, cnt_data_d;
  logic [2:0]        cnt_cmd_q, cnt_cmd_d;
  logic [1:0]        err_q, err_d;

  always_comb begin
    cnt_valid_d = issue_load;
    cnt_id_d    = cnt_id_q;
    cnt_data_d  = cnt_data_q;
    cnt_cmd_d   = cnt_cmd_q;
    if (issue_load) begin
      cnt_id_d   = head_id;
      cnt_data_d = head_data;
      cnt_cmd_d  = head_cmd;
    end
    err_d = err_q | {rsp_spurious, illegal};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_valid_q <= 1'b0;
      cnt_id_q    <= '0;
      cnt_data_q  <= '0;
      cnt_cmd_q   <= '0;
      inflight_q  <= '0;
      err_q       <= '0;
    end else begin
      cnt_valid_q <= cnt_valid_d;
      cnt_id_q    <= cnt_id_d;
      cnt_data_q  <= cnt_data_d;
      cnt_cmd_q   <= cnt_cmd_d;
      inflight_q  <= inflight_d;
      err_q       <= err_d;
    end
  end

  assign cnt_valid = cnt_valid_q;
  assign cnt_id    = cnt_id_q;
  assign cnt_data  = cnt_data_q;
  assign cnt_cmd   = cnt_cmd_q;
  assign err       = err_q;
  assign busy      = (req_count != '0) | cnt_valid_q | (inflight_q != 2'd0) | rsp_valid;

`ifdef COUNTER_CMD_MASTER_STATS_EN
  // ------------------------------------------------------------------
  // Event counters. They wrap at 16 bits.
  // ------------------------------------------------------------------
  logic [15:0] stat_issued_q, stat_reads_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q <= '0;
      stat_reads_q  <= '0;
    end else begin
      if (cnt_valid_q) stat_issued_q <= stat_issued_q + 16'd1;
      if (rsp_push)    stat_reads_q  <= stat_reads_q + 16'd1;
    end
  end

  assign stat_issued = stat_issued_q;
  assign stat_reads  = stat_reads_q;
`endif

`ifndef SYNTHESIS
  // The credit rule must prevent a push into a full queue unless a pop happens on the same edge.
  rsp_no_overflow_a: assert property (@(posedge clk) disable iff (!rst_n)
    !(rsp_push && rsp_full && !rsp_pop));
  // A counter that answers one cycle after sampling keeps at most two READs in flight.
  inflight_bound_a: assert property (@(posedge clk) disable iff (!rst_n)
    inflight_q != 2'd3);
`endif

endmodule

// File: tb/tb_counter_cmd_master.sv
// Directed bench for counter_cmd_master. It includes a behavioural model of the counter
// block, which answers a READ one cycle after sampling the command.

module tb_counter_cmd_master;

  localparam logic [2:0] Load = 3'd0, Clear = 3'd1, Inc = 3'd2, Dec = 3'd3, Read = 3'd4;

  logic       clk, rst_n;
  logic       req_valid, req_ready;
  logic [7:0] req_id, req_data;
  logic [2:0] req_cmd;
  logic       cnt_valid;
  logic [7:0] cnt_id, cnt_data;
  logic [2:0] cnt_cmd;
  logic       cnt_rsp_valid;
  logic [7:0] cnt_rsp_data;
  logic       rsp_valid, rsp_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [1:0] err;
`ifdef COUNTER_CMD_MASTER_STATS_EN
  logic [15:0] stat_issued, stat_reads;
`endif

  counter_cmd_master #(
    .ID_W(8), .DATA_W(8), .REQ_DEPTH(4), .RSP_DEPTH(4)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_id(req_id), .req_data(req_data), .req_cmd(req_cmd),
    .cnt_valid(cnt_valid), .cnt_id(cnt_id), .cnt_data(cnt_data), .cnt_cmd(cnt_cmd),
    .cnt_rsp_valid(cnt_rsp_valid), .cnt_rsp_data(cnt_rsp_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .busy(busy), .err(err)
`ifdef COUNTER_CMD_MASTER_STATS_EN
    ,
    .stat_issued(stat_issued), .stat_reads(stat_reads)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counter model. A READ sampled at an edge drives output_valid for the next cycle.
  logic [7:0] cmem [256];
  logic       m_valid;
  logic [7:0] m_data;
  logic       spur;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      for (int i = 0; i < 256; i++) cmem[i] <= 8'h00;
    end else begin
      m_valid <= 1'b0;
      if (cnt_valid) begin
        case (cnt_cmd)
          Load:  cmem[cnt_id] <= cnt_data;
          Clear: cmem[cnt_id] <= 8'h00;
          Inc:   cmem[cnt_id] <= cmem[cnt_id] + 8'd1;
          Dec:   cmem[cnt_id] <= cmem[cnt_id] - 8'd1;
          Read:  begin m_valid <= 1'b1; m_data <= cmem[cnt_id]; end
          default: ;
        endcase
      end
    end
  end

  assign cnt_rsp_valid = m_valid | spur;
  assign cnt_rsp_data  = m_data;

  // Issue monitor, sampled on the falling edge
  int         cyc;
  int         iss_cyc[$];
  logic [2:0] iss_cmd[$];
  logic [7:0] iss_id[$];
  logic [7:0] iss_data[$];

  initial cyc = 0;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst_n && cnt_valid) begin
      iss_cyc.push_back(cyc);
      iss_cmd.push_back(cnt_cmd);
      iss_id.push_back(cnt_id);
      iss_data.push_back(cnt_data);
    end
  end

  int n_checks, n_errs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hold a request until it is accepted. Returns on the falling edge after acceptance.
  task automatic send(input logic [2:0] cmd, input logic [7:0] id, input logic [7:0] data);
    int t;
    req_valid = 1'b1;
    req_cmd   = cmd;
    req_id    = id;
    req_data  = data;
    t = 0;
    while (!req_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check_eq("send_timeout", 32'(req_ready), 1);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, lat, got, t;
    n_checks = 0;
    n_errs   = 0;
    rst_n = 1'b0; req_valid = 1'b0; req_id = 8'h00; req_data = 8'h00; req_cmd = 3'd0;
    rsp_ready = 1'b0; spur = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_req_ready", 32'(req_ready), 0);
    check_eq("rst_cnt_valid", 32'(cnt_valid), 0);
    check_eq("rst_busy", 32'(busy), 0);
    check_eq("rst_err", 32'(err), 0);
    check_eq("rst_rsp_valid", 32'(rsp_valid), 0);

    // Reset release: ready stays low for one cycle, then goes high
    rst_n = 1'b1;
    #1;
    check_eq("rel_ready_low", 32'(req_ready), 0);
    @(negedge clk);
    check_eq("rel_ready_high", 32'(req_ready), 1);
    check_eq("rel_cnt_valid", 32'(cnt_valid), 0);
    check_eq("rel_err", 32'(err), 0);

    // Back-to-back LOAD 0x10, INC, READ on id 5
    n0 = iss_cyc.size();
    send(Load, 8'd5, 8'h10);
    send(Inc, 8'd5, 8'h00);
    send(Read, 8'd5, 8'h00);
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq("b2b_read_latency", 32'(lat), 3);
    check_eq("b2b_rsp_data", 32'(rsp_data), 32'h11);
    check_eq("b2b_issue_count", 32'(iss_cyc.size() - n0), 3);
    if (iss_cyc.size() - n0 >= 3) begin
      check_eq("b2b_consecutive", 32'(iss_cyc[n0+2] - iss_cyc[n0]), 2);
      check_eq("b2b_load_data", 32'(iss_data[n0]), 32'h10);
      check_eq("b2b_cmd2", 32'(iss_cmd[n0+2]), 32'(Read));
      check_eq("b2b_id2", 32'(iss_id[n0+2]), 5);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check_eq("b2b_drained", 32'(rsp_valid), 0);
    check_eq("b2b_busy_idle", 32'(busy), 0);

    // Backpressure: preload ids 0..7, then issue 8 READs while the host is not popping
    for (int i = 0; i < 8; i++) send(Load, 8'(i), 8'(8'hA0 + i));
    idle(3);
    n0 = iss_cyc.size();
    for (int i = 0; i < 8; i++) send(Read, 8'(i), 8'h00);
    req_valid = 1'b0;
    check_eq("bp_req_ready_low", 32'(req_ready), 0);
    idle(4);
    check_eq("bp_req_ready_still_low", 32'(req_ready), 0);
    check_eq("bp_cnt_valid_stall", 32'(cnt_valid), 0);
    check_eq("bp_issued_4", 32'(iss_cyc.size() - n0), 4);
    check_eq("bp_busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    got = 0;
    t = 0;
    while (got < 8 && t < 100) begin
      if (rsp_valid) begin
        check_eq($sformatf("bp_drain%0d", got), 32'(rsp_data), 32'(8'hA0 + got));
        got++;
      end
      @(negedge clk);
      t++;
    end
    rsp_ready = 1'b0;
    check_eq("bp_drain_count", 32'(got), 8);
    check_eq("bp_issued_8", 32'(iss_cyc.size() - n0), 8);
    idle(2);
    check_eq("bp_empty", 32'(rsp_valid), 0);
    check_eq("bp_err_clean", 32'(err), 0);

    // Illegal command 111 between two INCs
    n0 = iss_cyc.size();
    send(Inc, 8'd3, 8'h00);
    send(3'b111, 8'd3, 8'h00);
    send(Inc, 8'd3, 8'h00);
    idle(4);
    check_eq("ill_err0", 32'(err), 1);
    check_eq("ill_issue_count", 32'(iss_cyc.size() - n0), 2);
    if (iss_cyc.size() - n0 >= 2) begin
      check_eq("ill_gap", 32'(iss_cyc[n0+1] - iss_cyc[n0]), 2);
      check_eq("ill_cmd0", 32'(iss_cmd[n0]), 32'(Inc));
      check_eq("ill_cmd1", 32'(iss_cmd[n0+1]), 32'(Inc));
    end

    // Spurious response while idle
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    check_eq("spur_err", 32'(err), 3);
    check_eq("spur_rsp_valid", 32'(rsp_valid), 0);
    check_eq("spur_busy", 32'(busy), 0);
    @(negedge clk);
    check_eq("spur_rsp_valid_later", 32'(rsp_valid), 0);

    // Reset with two READs in flight
    send(Read, 8'd5, 8'h00);
    send(Read, 8'd3, 8'h00);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("mid_busy", 32'(busy), 1);
    check_eq("mid_cnt_valid", 32'(cnt_valid), 1);
    rst_n = 1'b0;
    #1;
    check_eq("mrst_req_ready", 32'(req_ready), 0);
    check_eq("mrst_cnt_valid", 32'(cnt_valid), 0);
    check_eq("mrst_cnt_id", 32'(cnt_id), 0);
    check_eq("mrst_cnt_data", 32'(cnt_data), 0);
    check_eq("mrst_cnt_cmd", 32'(cnt_cmd), 0);
    check_eq("mrst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("mrst_rsp_data", 32'(rsp_data), 0);
    check_eq("mrst_busy", 32'(busy), 0);
    check_eq("mrst_err", 32'(err), 0);
    @(negedge clk);
    rst_n = 1'b1;
    idle(6);
    check_eq("post_rst_rsp_valid", 32'(rsp_valid), 0);
    check_eq("post_rst_err", 32'(err), 0);
    check_eq("post_rst_busy", 32'(busy), 0);
    check_eq("post_rst_ready", 32'(req_ready), 1);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
